// File: rtl/div_pkg.sv
// Shared types for the iterative divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/iter_div_dp.sv
// Divider datapath: operand capture, restoring shift-subtract and
// result fix-up. Signed operands when ITER_DIV_SIGNED_EN is defined.
module iter_div_dp
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             cap,
    input  logic             init,
    input  logic             step,
    input  logic             ld_res,
    input  logic             ld_dz,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             dz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dvd, dvs;
    logic [WIDTH-1:0] a, q;
    logic [WIDTH-1:0] mag_n, mag_d;
    logic [WIDTH-1:0] q_res, r_res;
    logic [WIDTH:0]   trial;

`ifdef ITER_DIV_SIGNED_EN
    logic neg_n, neg_d;
    assign neg_n = dvd[WIDTH-1];
    assign neg_d = dvs[WIDTH-1];
    // MIN negates to itself, which is its correct unsigned magnitude
    assign mag_n = neg_n ? -dvd : dvd;
    assign mag_d = neg_d ? -dvs : dvs;
    assign q_res = (neg_n ^ neg_d) ? -q : q;
    assign r_res = neg_n ? -a : a;
`else
    assign mag_n = dvd;
    assign mag_d = dvs;
    assign q_res = q;
    assign r_res = a;
`endif

    assign dz    = (dvs == '0);
    assign trial = {a, q[WIDTH-1]} - {1'b0, mag_d};

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            dvd       <= '0;
            dvs       <= '0;
            a         <= '0;
            q         <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (cap) begin
                dvd <= dividend;
                dvs <= divisor;
            end
            if (init) begin
                a <= '0;
                q <= mag_n;
            end else if (step) begin
                if (!trial[WIDTH]) begin
                    a <= trial[WIDTH-1:0];
                    q <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    a <= {a[WIDTH-2:0], q[WIDTH-1]};
                    q <= {q[WIDTH-2:0], 1'b0};
                end
            end
            if (ld_res) begin
                quotient  <= q_res;
                remainder <= r_res;
            end else if (ld_dz) begin
                quotient  <= '1;
                remainder <= dvd;
            end
        end
    end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider: control FSM and iteration counter.
// Define ITER_DIV_SIGNED_EN for two's complement operands.
module iter_div
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             Go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    localparam int CW = cnt_w(WIDTH);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          cap, init, step;
    logic          ld_res, ld_dz, dz;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        cap    = 1'b0;
        init   = 1'b0;
        step   = 1'b0;
        ld_res = 1'b0;
        ld_dz  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Go) begin
                    cap = 1'b1;
                    nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (dz) begin
                    ld_dz = 1'b1;
                    nxt   = S_DONE;
                end else begin
                    init = 1'b1;
                    nxt  = S_ITER;
                end
            end
            S_ITER: begin
                step = 1'b1;
                if (cnt == '0) nxt = S_FIX;
            end
            S_FIX: begin
                ld_res = 1'b1;
                nxt    = S_DONE;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            Error <= 1'b0;
        end else begin
            if (init)
                cnt <= CW'(WIDTH - 1);
            else if (step && cnt != '0)
                cnt <= cnt - 1'b1;
            if (cap)
                Error <= 1'b0;
            else if (ld_dz)
                Error <= 1'b1;
        end
    end

    assign Busy = (state != S_IDLE);
    assign Done = (state == S_DONE);

    iter_div_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .CLK      (CLK),
        .rst      (rst),
        .cap      (cap),
        .init     (init),
        .step     (step),
        .ld_res   (ld_res),
        .ld_dz    (ld_dz),
        .dividend (dividend),
        .divisor  (divisor),
        .dz       (dz),
        .quotient (quotient),
        .remainder(remainder)
    );

endmodule
